fetch_pc_gen: RTL and testbench

Fetch-stage next-PC generator that drives the PC into the gshare direction predictor and consumes its taken/not-taken answer. Holds a direct-mapped BTB for targets and combines BTB hit with the gshare direction into the final fetch prediction. Checks execute-stage branch outcomes for mispredictions, redirects fetch, updates the BTB, and issues registered training updates to gshare. Also keeps branch and mispredict statistics counters.

---
 rtl/fetch_pc_gen.sv | 168 ++++++++++++++++
 tb/tb_fetch_pc_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator: direct-mapped BTB combined with an external
// gshare direction, execute-stage mispredict recovery, gshare training and stats.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BTB_IDX_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        gshare_pred_in,
  output logic [31:0] pc_out,
  output logic        pc_valid_out,
  output logic        pred_taken_out,
  output logic [31:0] pred_target_out,
  input  logic        ex_valid_in,
  input  logic        ex_is_branch_in,
  input  logic [31:0] ex_pc_in,
  input  logic        ex_taken_in,
  input  logic [31:0] ex_target_in,
  input  logic        ex_pred_taken_in,
  input  logic [31:0] ex_pred_target_in,
  output logic        flush_out,
  output logic        gshare_upd_valid_out,
  output logic [31:0] gshare_upd_pc_out,
  output logic        gshare_upd_taken_out,
  output logic [31:0] branch_cnt_out,
  output logic [31:0] mispred_cnt_out
);

  localparam int BTB_ENTRIES = 1 << BTB_IDX_W;
  localparam int TAG_W       = 30 - BTB_IDX_W;

  logic [31:0]          pc_reg;
  logic [31:0]          pc_next;
  logic                 pc_valid_reg;
  logic [BTB_ENTRIES-1:0] btb_valid_reg;
  logic [TAG_W-1:0]     btb_tag_mem    [BTB_ENTRIES];
  logic [29:0]          btb_target_mem [BTB_ENTRIES];

  logic                 upd_valid_reg;
  logic [31:0]          upd_pc_reg;
  logic                 upd_taken_reg;
  logic [31:0]          branch_cnt_reg;
  logic [31:0]          mispred_cnt_reg;

  // Fetch-side lookup
  logic [BTB_IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0]     fetch_tag;
  logic                 btb_hit;
  logic [31:0]          pc_plus4;
  logic                 pred_taken;
  logic [31:0]          pred_target;

  // Execute-side resolution
  logic [BTB_IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0]     ex_tag;
  logic                 ex_branch;
  logic                 ex_taken_branch;
  logic [31:0]          ex_pc_plus4;
  logic [31:0]          correct_pc;
  logic                 mispred;

  assign fetch_idx = pc_reg[BTB_IDX_W+1:2];
  assign fetch_tag = pc_reg[31:BTB_IDX_W+2];
  assign btb_hit   = btb_valid_reg[fetch_idx] && (btb_tag_mem[fetch_idx] == fetch_tag);
  assign pc_plus4  = (pc_reg + 32'd4) & 32'hFFFF_FFFC;

  assign pred_taken  = pc_valid_reg && btb_hit && gshare_pred_in;
  assign pred_target = pred_taken ? {btb_target_mem[fetch_idx], 2'b00} : pc_plus4;

  assign ex_idx          = ex_pc_in[BTB_IDX_W+1:2];
  assign ex_tag          = ex_pc_in[31:BTB_IDX_W+2];
  assign ex_branch       = ex_valid_in && ex_is_branch_in;
  assign ex_taken_branch = ex_branch && ex_taken_in;
  assign ex_pc_plus4     = (ex_pc_in + 32'd4) & 32'hFFFF_FFFC;

  always_comb begin
    correct_pc = ex_pc_plus4;
    if (ex_is_branch_in && ex_taken_in) begin
      correct_pc = ex_target_in & 32'hFFFF_FFFC;
    end
  end

  // A taken prediction on a non-branch (BTB alias) falls out of the target
  // compare, since correct_pc is then the fall-through address.
  always_comb begin
    mispred = 1'b0;
    if (ex_valid_in) begin
      if (ex_pred_taken_in) begin
        mispred = (ex_pred_target_in != correct_pc);
      end else begin
        mispred = ex_is_branch_in && ex_taken_in;
      end
    end
  end

  // The first valid cycle after reset fetches RESET_PC itself, so hold until then.
  always_comb begin
    pc_next = pc_reg;
    if (mispred) begin
      pc_next = correct_pc;
    end else if (!stall_in && pc_valid_reg) begin
      pc_next = pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg       <= RESET_PC & 32'hFFFF_FFFC;
      pc_valid_reg <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      pc_valid_reg <= 1'b1;
    end
  end

  // Valid bits need reset; tag/target storage is plain RAM written on taken branches.
  generate
    for (genvar gi = 0; gi < BTB_ENTRIES; gi++) begin : g_btb_valid
      always_ff @(posedge clk) begin
        if (reset) begin
          btb_valid_reg[gi] <= 1'b0;
        end else if (ex_taken_branch && (ex_idx == BTB_IDX_W'(gi))) begin
          btb_valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (ex_taken_branch) begin
      btb_tag_mem[ex_idx]    <= ex_tag;
      btb_target_mem[ex_idx] <= ex_target_in[31:2];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_valid_reg   <= 1'b0;
      upd_pc_reg      <= 32'd0;
      upd_taken_reg   <= 1'b0;
      branch_cnt_reg  <= 32'd0;
      mispred_cnt_reg <= 32'd0;
    end else begin
      upd_valid_reg <= ex_branch;
      upd_pc_reg    <= ex_pc_in;
      upd_taken_reg <= ex_taken_in;
      if (ex_branch) begin
        branch_cnt_reg <= branch_cnt_reg + 32'd1;
      end
      if (mispred) begin
        mispred_cnt_reg <= mispred_cnt_reg + 32'd1;
      end
    end
  end

  assign pc_out               = pc_reg;
  assign pc_valid_out         = pc_valid_reg;
  assign pred_taken_out       = pred_taken;
  assign pred_target_out      = pred_target;
  assign flush_out            = mispred;
  assign gshare_upd_valid_out = upd_valid_reg;
  assign gshare_upd_pc_out    = upd_pc_reg;
  assign gshare_upd_taken_out = upd_taken_reg;
  assign branch_cnt_out       = branch_cnt_reg;
  assign mispred_cnt_out      = mispred_cnt_reg;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed scoreboard bench for fetch_pc_gen: each driven cycle pushes its
// hand-computed expected outputs; a negedge monitor pops and compares.
module tb_fetch_pc_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_in;
  logic        gshare_pred_in;
  logic [31:0] pc_out;
  logic        pc_valid_out;
  logic        pred_taken_out;
  logic [31:0] pred_target_out;
  logic        ex_valid_in;
  logic        ex_is_branch_in;
  logic [31:0] ex_pc_in;
  logic        ex_taken_in;
  logic [31:0] ex_target_in;
  logic        ex_pred_taken_in;
  logic [31:0] ex_pred_target_in;
  logic        flush_out;
  logic        gshare_upd_valid_out;
  logic [31:0] gshare_upd_pc_out;
  logic        gshare_upd_taken_out;
  logic [31:0] branch_cnt_out;
  logic [31:0] mispred_cnt_out;

  fetch_pc_gen #(.RESET_PC(32'h0000_0100), .BTB_IDX_W(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .stall_in            (stall_in),
    .gshare_pred_in      (gshare_pred_in),
    .pc_out              (pc_out),
    .pc_valid_out        (pc_valid_out),
    .pred_taken_out      (pred_taken_out),
    .pred_target_out     (pred_target_out),
    .ex_valid_in         (ex_valid_in),
    .ex_is_branch_in     (ex_is_branch_in),
    .ex_pc_in            (ex_pc_in),
    .ex_taken_in         (ex_taken_in),
    .ex_target_in        (ex_target_in),
    .ex_pred_taken_in    (ex_pred_taken_in),
    .ex_pred_target_in   (ex_pred_target_in),
    .flush_out           (flush_out),
    .gshare_upd_valid_out(gshare_upd_valid_out),
    .gshare_upd_pc_out   (gshare_upd_pc_out),
    .gshare_upd_taken_out(gshare_upd_taken_out),
    .branch_cnt_out      (branch_cnt_out),
    .mispred_cnt_out     (mispred_cnt_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        pv;
    logic        pt;
    logic [31:0] ptgt;
    logic        fl;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   pushed   = 0;
  int   popped   = 0;

  task automatic cmp(input string name, input int txn, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL txn=%0d %s actual=%h required=%h", txn, name, act, req);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, after inputs have settled.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      int   fails_before;
      e = exp_q.pop_front();
      fails_before = failures;
      cmp("pc_out",          popped, pc_out,                      e.pc);
      cmp("pc_valid_out",    popped, 32'(pc_valid_out),           32'(e.pv));
      cmp("pred_taken_out",  popped, 32'(pred_taken_out),         32'(e.pt));
      cmp("pred_target_out", popped, pred_target_out,             e.ptgt);
      cmp("flush_out",       popped, 32'(flush_out),              32'(e.fl));
      cmp("upd_valid",       popped, 32'(gshare_upd_valid_out),   32'(e.uv));
      cmp("upd_pc",          popped, gshare_upd_pc_out,           e.upc);
      cmp("upd_taken",       popped, 32'(gshare_upd_taken_out),   32'(e.ut));
      cmp("branch_cnt",      popped, branch_cnt_out,              e.bc);
      cmp("mispred_cnt",     popped, mispred_cnt_out,             e.mc);
      $display("txn %0d pc=%h pv=%0d pt=%0d ptgt=%h fl=%0d upd=%0d/%h/%0d cnt=%0d/%0d %s",
               popped, pc_out, pc_valid_out, pred_taken_out, pred_target_out, flush_out,
               gshare_upd_valid_out, gshare_upd_pc_out, gshare_upd_taken_out,
               branch_cnt_out, mispred_cnt_out, (failures == fails_before) ? "ok" : "bad");
      popped++;
    end
  end

  task automatic drive(input logic rst, input logic stall, input logic gp,
                       input logic exv, input logic exb, input logic [31:0] expc,
                       input logic ext, input logic [31:0] extgt,
                       input logic expt, input logic [31:0] exptgt);
    reset             = rst;
    stall_in          = stall;
    gshare_pred_in    = gp;
    ex_valid_in       = exv;
    ex_is_branch_in   = exb;
    ex_pc_in          = expc;
    ex_taken_in       = ext;
    ex_target_in      = extgt;
    ex_pred_taken_in  = expt;
    ex_pred_target_in = exptgt;
  endtask

  task automatic idle(input logic rst, input logic stall, input logic gp);
    drive(rst, stall, gp, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic expect_out(input logic [31:0] pc, input logic pv, input logic pt,
                            input logic [31:0] ptgt, input logic fl, input logic uv,
                            input logic [31:0] upc, input logic ut,
                            input logic [31:0] bc, input logic [31:0] mc);
    exp_t e;
    e.pc = pc; e.pv = pv; e.pt = pt; e.ptgt = ptgt; e.fl = fl;
    e.uv = uv; e.upc = upc; e.ut = ut; e.bc = bc; e.mc = mc;
    exp_q.push_back(e);
    pushed++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle(1'b1, 1'b0, 1'b0);
    tick;
    // Reset held, then released: PC sits at RESET_PC, valid rises one cycle later.
    idle(1'b1, 1'b0, 1'b0); expect_out(32'h100, 0, 0, 32'h104, 0, 0, 32'h0, 0, 0, 0); tick;
    idle(1'b0, 1'b0, 1'b0); expect_out(32'h100, 0, 0, 32'h104, 0, 0, 32'h0, 0, 0, 0); tick;
    idle(1'b0, 1'b0, 1'b0); expect_out(32'h100, 1, 0, 32'h104, 0, 0, 32'h0, 0, 0, 0); tick;
    idle(1'b0, 1'b0, 1'b0); expect_out(32'h104, 1, 0, 32'h108, 0, 0, 32'h0, 0, 0, 0); tick;
    // Taken branch 0x108->0x200 predicted not-taken.
    drive(0, 0, 0, 1, 1, 32'h108, 1, 32'h200, 0, 32'h10C);
    expect_out(32'h108, 1, 0, 32'h10C, 1, 0, 32'h0, 0, 0, 0); tick;
    idle(1'b0, 1'b0, 1'b0); expect_out(32'h200, 1, 0, 32'h204, 0, 1, 32'h108, 1, 1, 1); tick;
    // Redirect back to 0x108 via another mispredicted branch at 0x50.
    drive(0, 0, 0, 1, 1, 32'h50, 1, 32'h108, 0, 32'h54);
    expect_out(32'h204, 1, 0, 32'h208, 1, 0, 32'h0, 0, 1, 1); tick;
    // BTB hit with gshare taken.
    idle(1'b0, 1'b0, 1'b1); expect_out(32'h108, 1, 1, 32'h200, 0, 1, 32'h50, 1, 2, 2); tick;
    drive(0, 0, 1, 1, 1, 32'h60, 1, 32'h108, 0, 32'h64);
    expect_out(32'h200, 1, 0, 32'h204, 1, 0, 32'h0, 0, 2, 2); tick;
    // BTB hit with gshare not-taken: fall through.
    idle(1'b0, 1'b0, 1'b0); expect_out(32'h108, 1, 0, 32'h10C, 0, 1, 32'h60, 1, 3, 3); tick;
    // Stall three cycles; wrong-target mispredict in the last one overrides stall.
    idle(1'b0, 1'b1, 1'b0); expect_out(32'h10C, 1, 0, 32'h110, 0, 0, 32'h0, 0, 3, 3); tick;
    idle(1'b0, 1'b1, 1'b0); expect_out(32'h10C, 1, 0, 32'h110, 0, 0, 32'h0, 0, 3, 3); tick;
    drive(0, 1, 0, 1, 1, 32'h80, 1, 32'h300, 1, 32'h280);
    expect_out(32'h10C, 1, 0, 32'h110, 1, 0, 32'h0, 0, 3, 3); tick;
    // Non-branch predicted taken (alias): fall-through redirect, no training.
    drive(0, 0, 0, 1, 0, 32'h148, 0, 32'h0, 1, 32'h200);
    expect_out(32'h300, 1, 0, 32'h304, 1, 1, 32'h80, 1, 4, 4); tick;
    idle(1'b0, 1'b0, 1'b0); expect_out(32'h14C, 1, 0, 32'h150, 0, 0, 32'h148, 0, 4, 5); tick;
    // Correctly predicted taken branch: counted, no flush.
    drive(0, 0, 0, 1, 1, 32'h108, 1, 32'h200, 1, 32'h200);
    expect_out(32'h150, 1, 0, 32'h154, 0, 0, 32'h0, 0, 4, 5); tick;
    drive(0, 0, 0, 1, 1, 32'h90, 1, 32'h80, 0, 32'h94);
    expect_out(32'h154, 1, 0, 32'h158, 1, 1, 32'h108, 1, 5, 5); tick;
    // 0x80 hits the entry written during the stall.
    idle(1'b0, 1'b0, 1'b1); expect_out(32'h80, 1, 1, 32'h300, 0, 1, 32'h90, 1, 6, 6); tick;
    // Mid-stream reset.
    idle(1'b1, 1'b0, 1'b0); expect_out(32'h300, 1, 0, 32'h304, 0, 0, 32'h0, 0, 6, 6); tick;
    idle(1'b0, 1'b0, 1'b1); expect_out(32'h100, 0, 0, 32'h104, 0, 0, 32'h0, 0, 0, 0); tick;
    idle(1'b0, 1'b0, 1'b1); expect_out(32'h100, 1, 0, 32'h104, 0, 0, 32'h0, 0, 0, 0); tick;
    idle(1'b0, 1'b0, 1'b1); expect_out(32'h104, 1, 0, 32'h108, 0, 0, 32'h0, 0, 0, 0); tick;
    // BTB was cleared: 0x108 no longer hits even with gshare taken.
    idle(1'b0, 1'b0, 1'b1); expect_out(32'h108, 1, 0, 32'h10C, 0, 0, 32'h0, 0, 0, 0); tick;
    idle(1'b0, 1'b0, 1'b0);
    tick;
    tick;
    cmp("scoreboard_drained", popped, 32'(popped), 32'(pushed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
